hazard_unit: RTL and testbench

- Hazard detection and forwarding-select block for the 5-stage RISC-V core.
- Sits beside the ID stage. Consumes the decoder's per-instruction hazard class, register-use flags, register indices and the ID-resolved branch/jump signal.
- Keeps its own shadow pipeline of hazard class, rd and rs2 for EX, MEM and WB.
- Drives PC/IF-ID enables, the IF-ID and ID-EX flushes, and the operand and store-data forwarding selects.

---
 rtl/core_pkg.sv | 29 ++
 rtl/hazard_fwd_sel.sv | 34 +++
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: hazard classes, forwarding selects and the hazard shadow-slot type.
package core_pkg;

    localparam int unsigned HZ_REG_AW = 5;

    localparam logic [1:0] HZ_NONE  = 2'b00;
    localparam logic [1:0] HZ_ALU   = 2'b01;
    localparam logic [1:0] HZ_LOAD  = 2'b10;
    localparam logic [1:0] HZ_STORE = 2'b11;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef struct packed {
        logic [1:0]           optype;
        logic [HZ_REG_AW-1:0] rd;
        logic [HZ_REG_AW-1:0] rs2;
    } hz_slot_t;

    // x0 is hardwired zero, so a write to it never produces a dependency.
    function automatic logic slot_writes(input logic [1:0]           optype,
                                         input logic [HZ_REG_AW-1:0] rd,
                                         input logic [HZ_REG_AW-1:0] r);
        return ((optype == HZ_ALU) || (optype == HZ_LOAD)) && (rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority selector choosing the ID-stage operand source from the EX and MEM shadow slots.
module hazard_fwd_sel
    import core_pkg::*;
(
    input  logic [HZ_REG_AW-1:0] reg_idx_i,
    input  logic                 use_i,
    input  logic [1:0]           ex_optype_i,
    input  logic [HZ_REG_AW-1:0] ex_rd_i,
    input  logic [1:0]           mem_optype_i,
    input  logic [HZ_REG_AW-1:0] mem_rd_i,
    output logic [1:0]           fwd_sel_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = slot_writes(ex_optype_i, ex_rd_i, reg_idx_i);
    assign mem_hit = slot_writes(mem_optype_i, mem_rd_i, reg_idx_i);

    // The youngest producer wins; a load still in EX is handled by the stall, not here.
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (use_i) begin
            if (ex_hit && (ex_optype_i == HZ_ALU)) begin
                fwd_sel_o = FWD_EX_ALU;
            end else if (mem_hit && (mem_optype_i == HZ_ALU)) begin
                fwd_sel_o = FWD_MEM_ALU;
            end else if (mem_hit && (mem_optype_i == HZ_LOAD)) begin
                fwd_sel_o = FWD_MEM_LD;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control beside ID; tracks EX/MEM/WB in its own shadow slots.
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              Branch_ID,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls
);

    logic [HZ_REG_AW-1:0] rs1_idx;
    logic [HZ_REG_AW-1:0] rs2_idx;
    logic [HZ_REG_AW-1:0] rd_idx;

    assign rs1_idx = HZ_REG_AW'(rs1_ID);
    assign rs2_idx = HZ_REG_AW'(rs2_ID);
    assign rd_idx  = HZ_REG_AW'(rd_ID);

    hz_slot_t ex_d, ex_q;
    hz_slot_t mem_q;
    // WB only ever needs class and rd (for the store-data check), so rs2 is dropped there.
    logic [1:0]           wb_optype_q;
    logic [HZ_REG_AW-1:0] wb_rd_q;

    logic load_use_stall;

    // A store's rs2 is only needed in MEM, so a load feeding it never stalls.
    always_comb begin
        load_use_stall = 1'b0;
        if (ex_q.optype == HZ_LOAD) begin
            if (rs1use_ID && slot_writes(ex_q.optype, ex_q.rd, rs1_idx)) begin
                load_use_stall = 1'b1;
            end
            if (rs2use_ID && (hazard_optype_ID != HZ_STORE) &&
                slot_writes(ex_q.optype, ex_q.rd, rs2_idx)) begin
                load_use_stall = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d.optype = hazard_optype_ID;
        ex_d.rd     = rd_idx;
        ex_d.rs2    = rs2_idx;
        if (load_use_stall) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_optype_q <= HZ_NONE;
            wb_rd_q     <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_optype_q <= mem_q.optype;
            wb_rd_q     <= mem_q.rd;
        end
    end

    // A stall beats a branch: the branch operands are not valid yet and ID re-resolves it.
    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_EN    = 1'b1;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        if (load_use_stall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_flush = 1'b1;
        end else if (Branch_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    assign forward_ctrl_ls = (mem_q.optype == HZ_STORE) && (wb_optype_q == HZ_LOAD) &&
                             (wb_rd_q == mem_q.rs2) && (wb_rd_q != '0);

    hazard_fwd_sel u_fwd_sel_a (
        .reg_idx_i    (rs1_idx),
        .use_i        (rs1use_ID),
        .ex_optype_i  (ex_q.optype),
        .ex_rd_i      (ex_q.rd),
        .mem_optype_i (mem_q.optype),
        .mem_rd_i     (mem_q.rd),
        .fwd_sel_o    (forward_ctrl_A)
    );

    hazard_fwd_sel u_fwd_sel_b (
        .reg_idx_i    (rs2_idx),
        .use_i        (rs2use_ID),
        .ex_optype_i  (ex_q.optype),
        .ex_rd_i      (ex_q.rd),
        .mem_optype_i (mem_q.optype),
        .mem_rd_i     (mem_q.rd),
        .fwd_sel_o    (forward_ctrl_B)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized bench for hazard_unit against a history-based reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] hazard_optype_ID;
    logic       rs1use_ID, rs2use_ID, Branch_ID;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_ls;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazard_optype_ID (hazard_optype_ID),
        .rs1use_ID        (rs1use_ID),
        .rs2use_ID        (rs2use_ID),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .rd_ID            (rd_ID),
        .Branch_ID        (Branch_ID),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_flush     (reg_FD_flush),
        .reg_DE_flush     (reg_DE_flush),
        .forward_ctrl_A   (forward_ctrl_A),
        .forward_ctrl_B   (forward_ctrl_B),
        .forward_ctrl_ls  (forward_ctrl_ls)
    );

    // {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, A, B, ls}
    logic [8:0] obs;
    assign obs = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
                  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};

    localparam logic [8:0] IDLE  = 9'b11_00_00_00_0;
    localparam logic [8:0] STALL = 9'b00_01_00_00_0;

    int vectors = 0;
    int miscompares = 0;

    // Instruction history as issued past ID: [0] is in EX, [1] in MEM, [2] in WB.
    typedef struct {
        int op;
        int rd;
        int rs2;
    } mslot_t;

    mslot_t hist [3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};

    function automatic bit m_writes(mslot_t s, int r);
        return (s.op == 1 || s.op == 2) && s.rd == r && r != 0;
    endfunction

    function automatic bit m_stall();
        int op = int'(hazard_optype_ID);
        if (hist[0].op != 2) return 1'b0;
        if (rs1use_ID && m_writes(hist[0], int'(rs1_ID))) return 1'b1;
        if (rs2use_ID && op != 3 && m_writes(hist[0], int'(rs2_ID))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(bit u, int r);
        if (!u) return 2'd0;
        if (hist[0].op == 1 && m_writes(hist[0], r)) return 2'd1;
        if (hist[1].op == 1 && m_writes(hist[1], r)) return 2'd2;
        if (hist[1].op == 2 && m_writes(hist[1], r)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [8:0] m_out();
        bit st = m_stall();
        bit ls = hist[1].op == 3 && hist[2].op == 2 && hist[2].rd == hist[1].rs2 &&
                 hist[2].rd != 0;
        return {~st, ~st, (Branch_ID && !st), st,
                m_fwd(rs1use_ID, int'(rs1_ID)), m_fwd(rs2use_ID, int'(rs2_ID)), ls};
    endfunction

    function automatic mslot_t m_issue();
        mslot_t n = '{0, 0, 0};
        if (!m_stall()) n = '{int'(hazard_optype_ID), int'(rd_ID), int'(rs2_ID)};
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= '{0, 0, 0};
            hist[1] <= '{0, 0, 0};
            hist[2] <= '{0, 0, 0};
        end else begin
            hist[0] <= m_issue();
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    task automatic check(input string tag, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int op, input bit u1, input bit u2, input int r1,
                         input int r2, input int rd, input bit br);
        hazard_optype_ID = 2'(op);
        rs1use_ID        = u1;
        rs2use_ID        = u2;
        rs1_ID           = 5'(r1);
        rs2_ID           = 5'(r2);
        rd_ID            = 5'(rd);
        Branch_ID        = br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int op, input bit u1, input bit u2,
                        input int r1, input int r2, input int rd, input bit br,
                        input logic [8:0] exp);
        drive(op, u1, u2, r1, r2, rd, br);
        #3;
        check(tag, exp);
        next_cycle();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset", IDLE);
        next_cycle();
        rst_n = 1'b1;

        // ALU-use forwarding from EX then MEM
        step("alu_issue", 1, 0, 0, 0, 0, 5, 0, IDLE);
        step("alu_use_ex", 1, 1, 1, 5, 6, 9, 0, 9'b11_00_01_00_0);
        step("alu_use_mem", 0, 1, 0, 5, 0, 0, 0, 9'b11_00_10_00_0);

        // Load-use: one bubble then MEM load forwarding
        step("ld_issue", 2, 0, 0, 0, 0, 7, 0, IDLE);
        step("ld_use_stall", 1, 1, 0, 7, 0, 10, 0, STALL);
        step("ld_use_fwd", 1, 1, 0, 7, 0, 10, 0, 9'b11_00_11_00_0);

        // Load then store of the loaded value: no stall, ls select for one cycle
        step("ldst_ld", 2, 0, 0, 0, 0, 8, 0, IDLE);
        step("ldst_st", 3, 1, 1, 2, 8, 0, 0, IDLE);
        step("ldst_gap", 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("ldst_ls", 0, 0, 0, 0, 0, 0, 0, 9'b11_00_00_00_1);
        step("ldst_ls_off", 0, 0, 0, 0, 0, 0, 0, IDLE);

        // x0 never forwards
        step("x0_issue", 1, 0, 0, 0, 0, 0, 0, IDLE);
        step("x0_use", 1, 1, 0, 0, 0, 3, 0, IDLE);

        // Branch flush, and branch held off by a load-use stall
        step("br_flush", 0, 0, 0, 0, 0, 0, 1, 9'b11_10_00_00_0);
        step("br_done", 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("brld_issue", 2, 0, 0, 0, 0, 4, 0, IDLE);
        step("brld_stall", 0, 1, 0, 4, 0, 0, 1, STALL);
        step("brld_flush", 0, 1, 0, 4, 0, 0, 1, 9'b11_10_11_00_0);

        // Reset asserted during a load-use stall
        step("rst_ld_issue", 2, 0, 0, 0, 0, 6, 0, IDLE);
        drive(1, 1, 0, 6, 0, 11, 0);
        #3;
        check("rst_pre_stall", STALL);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", IDLE);
        next_cycle();
        drive(0, 1, 0, 6, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("rst_slots_empty", IDLE);
            next_cycle();
        end

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            int op = $urandom_range(0, 3);
            bit u1 = 1'($urandom_range(0, 1));
            bit u2 = (op == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            bit br = ($urandom_range(0, 5) == 0);
            drive(op, u1, u2, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), br);
            #3;
            check("random", m_out());
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
